// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/word types, S-box table, round constants,
// and the GF(2^8) helpers used by MixColumns.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [WORD_W-1:0]  word_t;

  // Forward S-box; entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte a lives at bit offset 8*(255-a) = {~a, 3'b000}.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX[base +: 8];
  endfunction

  // Round constant for rounds 1..10.
  function automatic logic [7:0] rcon_f(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte 0 is the most significant byte.
  function automatic word_t mixcolumn(input word_t col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup.
// Ports: a - input byte, y - substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_f(a);

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock, free-running on the held
// plaintext/key. A new block is captured every 11 cycles.
// Ports: clk, rst_n (synchronous, active low), in (plaintext), key (cipher key),
//        out (registered ciphertext), out_valid (one-cycle pulse on update).
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         out_valid
);

  localparam int unsigned CW = 4;

  logic [CW-1:0] cnt;
  block_t        state;
  block_t        rk;
  block_t        sb;
  block_t        sr;
  block_t        mc;
  block_t        nk;
  block_t        rnd;
  word_t         rot;
  word_t         sw;

  // SubBytes on all sixteen state bytes.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .a(state[127-8*i -: 8]),
      .y(sb[127-8*i -: 8])
    );
  end

  // SubWord(RotWord(w3)) for the key schedule.
  assign rot = {rk[23:0], rk[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a(rot[31-8*i -: 8]),
      .y(sw[31-8*i -: 8])
    );
  end

  // ShiftRows: byte (row r, column c) takes byte (r, c+r mod 4).
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  // MixColumns per column.
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mixcolumn(sr[127-32*c -: 32]);
    end
  end

  // On-the-fly round key expansion.
  always_comb begin
    nk = '0;
    nk[127:96] = rk[127:96] ^ sw ^ {rcon_f(cnt), 24'h000000};
    nk[95:64]  = rk[95:64] ^ nk[127:96];
    nk[63:32]  = rk[63:32] ^ nk[95:64];
    nk[31:0]   = rk[31:0]  ^ nk[63:32];
  end

  // Last round skips MixColumns.
  assign rnd = (cnt == CW'(NR)) ? (sr ^ nk) : (mc ^ nk);

  // Round sequencer: capture, NR-1 full rounds, final round writes out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      state     <= '0;
      rk        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (cnt == '0) begin
        state <= in ^ key;
        rk    <= key;
        cnt   <= CW'(1);
      end else if (cnt == CW'(NR)) begin
        out       <= rnd;
        out_valid <= 1'b1;
        cnt       <= '0;
      end else begin
        state <= rnd;
        rk    <= nk;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter using known-answer vectors.
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] din;
  logic [127:0] dkey;
  logic [127:0] dout;
  logic         dvalid;

  int npass  = 0;
  int ntotal = 0;
  logic [127:0] sb_q[$];

  localparam logic [127:0] K1 = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
  localparam logic [127:0] C1 = 128'h0336763e966d92595a567cc9ce537f5e;
  localparam logic [127:0] K2 = 128'h9798c4640bad75c7c3227db910174e72;
  localparam logic [127:0] C2 = 128'ha9a1631bf4996954ebc093957b234589;
  localparam logic [127:0] K3 = 128'h58c8e00b2631686d54eab84b91f0aca1;
  localparam logic [127:0] C3 = 128'h08a4e2efec8a8e3312ca7460b9040bbf;

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .key      (dkey),
    .out      (dout),
    .out_valid(dvalid)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait up to limit falling edges for out_valid; flag any change of out before it.
  task automatic wait_pulse(input int limit, input logic [127:0] held,
                            output int n, output bit ok, output bit held_bad);
    n = 0;
    ok = 1'b0;
    held_bad = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (dvalid) begin
        n = i;
        ok = 1'b1;
        break;
      end
      if (dout !== held) held_bad = 1'b1;
    end
  endtask

  // Drive a vector; the second pulse after the change must carry its ciphertext.
  task automatic run_vec(input string tag, input logic [127:0] k,
                         input logic [127:0] p, input logic [127:0] c);
    int n1, n2;
    bit ok1, ok2, hb1, hb2;
    logic [127:0] stale, exp;
    dkey = k;
    din  = p;
    sb_q.push_back(c);
    stale = dout;
    wait_pulse(11, stale, n1, ok1, hb1);
    chk({tag, "_first"}, 128'(ok1), 128'd1);
    stale = dout;
    wait_pulse(11, stale, n2, ok2, hb2);
    chk({tag, "_gap"}, 128'(n2), 128'd11);
    chk({tag, "_lat22"}, 128'(ok2 && (n1 + n2 <= 22)), 128'd1);
    chk({tag, "_hold"}, 128'(hb1 | hb2), 128'd0);
    exp = sb_q.pop_front();
    chk({tag, "_ct"}, dout, exp);
    @(negedge clk);
    chk({tag, "_pulse1"}, 128'(dvalid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok, hb, early;
    logic [127:0] e;

    rst_n = 1'b0;
    din   = '0;
    dkey  = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", dout, 128'd0);
    chk("rst_valid", 128'(dvalid), 128'd0);

    rst_n = 1'b1;
    run_vec("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
            128'h00112233445566778899aabbccddeeff,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_vec("kat_p1", '0, K1, C1);
    run_vec("kat_p2", '0, K2, C2);
    run_vec("kat_p3", '0, K3, C3);
    run_vec("kat_k1", 128'h10a58869d74be5a374cf867cfb473859, '0,
            128'h6d251e6944b051e04eaa6fb4dbf78465);
    run_vec("kat_k2", 128'h71b5c08a1993e1362e4d0ce9b22b78d5, '0,
            128'hc2dabd117f8a3ecabfbb11d12194d9d0);

    // Reset mid-encryption, then exact latency from the first capture edge.
    din  = K1;
    dkey = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", dout, 128'd0);
    chk("mid_rst_valid", 128'(dvalid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(C1);
    early = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10 && dvalid) early = 1'b1;
    end
    chk("rel_early", 128'(early), 128'd0);
    chk("rel_valid", 128'(dvalid), 128'd1);
    e = sb_q.pop_front();
    chk("rel_ct", dout, e);

    // Counter is 0 here: next edge captures K2; glitch the input at counter 5.
    din = K2;
    sb_q.push_back(C2);
    repeat (5) @(negedge clk);
    din = K3;
    repeat (2) @(negedge clk);
    din = K2;
    wait_pulse(11, dout, n, ok, hb);
    chk("glitch_n", 128'(n), 128'd4);
    chk("glitch_hold", 128'(hb), 128'd0);
    e = sb_q.pop_front();
    chk("glitch_ct", dout, e);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
